// File: rtl/resized_crop.sv
// Random-resized-crop stage: buffers one square greyscale image, then streams a square crop
// nearest-neighbour upscaled back to full size. Optional macro CROP_CENTER_EN centres the crop.
module resized_crop #(
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned CROP_STEP = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] scale_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_last_o,
  output logic       img_done_o
);

  localparam int unsigned NPix = IMG_W * IMG_W;
  localparam int unsigned AW   = $clog2(NPix);
  localparam int unsigned CW   = $clog2(IMG_W + 1);
  localparam int unsigned AccW = $clog2(2 * IMG_W);

  typedef enum logic [1:0] {StIdle, StFill, StLoad, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [1:0]      scale_q, scale_d;
  logic [CW-1:0]   src_x_q, src_x_d, src_y_q, src_y_d, ox_q, ox_d;
  logic [AccW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [AW-1:0]   opix_q, opix_d; // output index of the pixel loaded next
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            img_done_q, img_done_d;

  logic [7:0]      mem_q [NPix];
  logic            wr_en, out_hs, load;
  logic [AccW-1:0] crop_c, acc_x_sum, acc_y_sum;
  logic [CW-1:0]   off;
  logic [AW-1:0]   rd_addr;

  assign in_ready_o  = (state_q == StIdle) || (state_q == StFill);
  assign wr_en       = in_valid_i && in_ready_o;
  assign out_hs      = out_valid_q && out_ready_i;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign img_done_o  = img_done_q;

  assign crop_c = AccW'(IMG_W - 32'(scale_q) * CROP_STEP);
`ifdef CROP_CENTER_EN
  assign off = CW'(32'(scale_q) * CROP_STEP / 32'd2);
`else
  assign off = '0;
`endif
  assign acc_x_sum = acc_x_q + crop_c;
  assign acc_y_sum = acc_y_q + crop_c;
  assign rd_addr   = AW'(32'(src_y_q) * IMG_W + 32'(src_x_q));
  assign load      = (state_q == StLoad) || ((state_q == StDrain) && out_hs && !out_last_q);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr_q] <= in_data_i;
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    scale_d     = scale_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    ox_d        = ox_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    opix_d      = opix_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    img_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          scale_d   = scale_i;
          wr_addr_d = wr_addr_q + AW'(1);
          state_d   = StFill;
        end
      end
      StFill: begin
        if (wr_en) begin
          if (wr_addr_q == AW'(NPix - 1)) begin
            wr_addr_d = '0;
            src_x_d   = off;
            src_y_d   = off;
            acc_x_d   = '0;
            acc_y_d   = '0;
            ox_d      = '0;
            opix_d    = '0;
            state_d   = StLoad;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      StLoad: state_d = StDrain;
      StDrain: begin
        if (out_hs && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          img_done_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Register the next crop pixel and step the DDA; the x axis restarts each output row.
    if (load) begin
      out_data_d  = mem_q[rd_addr];
      out_valid_d = 1'b1;
      out_last_d  = (opix_q == AW'(NPix - 1));
      opix_d      = opix_q + AW'(1);
      if (ox_q == CW'(IMG_W - 1)) begin
        ox_d    = '0;
        src_x_d = off;
        acc_x_d = '0;
        if (acc_y_sum >= AccW'(IMG_W)) begin
          acc_y_d = acc_y_sum - AccW'(IMG_W);
          src_y_d = src_y_q + CW'(1);
        end else begin
          acc_y_d = acc_y_sum;
        end
      end else begin
        ox_d = ox_q + CW'(1);
        if (acc_x_sum >= AccW'(IMG_W)) begin
          acc_x_d = acc_x_sum - AccW'(IMG_W);
          src_x_d = src_x_q + CW'(1);
        end else begin
          acc_x_d = acc_x_sum;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      scale_q     <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      ox_q        <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      opix_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      img_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      scale_q     <= scale_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      ox_q        <= ox_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      opix_q      <= opix_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      img_done_q  <= img_done_d;
    end
  end

endmodule
